// File: rtl/irq_pkg.sv
// ============================================================================
// Module : irq_pkg
// Brief  : Shared types and constants for the vectored interrupt controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } irq_state_t;

  localparam logic [9:0] c_vec_base_default   = 10'b1000000000;
  localparam int         c_vec_stride_default = 16;

  // A single source still needs a one-bit id bus.
  function automatic int irq_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module : interrupt_controller_if
// Brief  : Request, mask-write and dispatch signals between CPU and controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if
  import irq_pkg::*;
#(
  parameter int N_IRQ  = 4,
  parameter int ADDR_W = 10
);
  localparam int ID_W = irq_id_width(N_IRQ);

  logic [N_IRQ-1:0]  irq;
  logic              en_we;
  logic [N_IRQ-1:0]  en_wdata;
  logic              s_finished;
  logic              s_interruption;
  logic [ADDR_W-1:0] dir_out;
  logic [ID_W-1:0]   irq_id;
  logic              irq_take;
  logic [N_IRQ-1:0]  pending;

  modport master (
    output irq, en_we, en_wdata, s_finished,
    input  s_interruption, dir_out, irq_id, irq_take, pending
  );

  modport slave (
    input  irq, en_we, en_wdata, s_finished,
    output s_interruption, dir_out, irq_id, irq_take, pending
  );

endinterface

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module : irq_prio_enc
// Brief  : Combinational lowest-index-wins priority encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = irq_id_width(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module : interrupt_controller
// Brief  : N-source non-nesting vectored interrupt controller with enable mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module interrupt_controller
  import irq_pkg::*;
#(
  parameter int                N_IRQ      = 4,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(c_vec_base_default),
  parameter int                VEC_STRIDE = c_vec_stride_default,
  parameter bit                EDGE_MODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_controller_if.slave bus
);

  localparam int ID_W = irq_id_width(N_IRQ);

  irq_state_t        r_state;
  irq_state_t        w_state_next;
  logic [N_IRQ-1:0]  r_pending;
  logic [N_IRQ-1:0]  r_enable;
  logic [N_IRQ-1:0]  w_set;
  logic [N_IRQ-1:0]  w_clr;
  logic [N_IRQ-1:0]  w_cand;
  logic              w_found;
  logic              w_dispatch;
  logic [ID_W-1:0]   w_sel;
  logic [ADDR_W-1:0] w_vec;
  logic [ADDR_W-1:0] r_dir;
  logic [ID_W-1:0]   r_id;
  logic              r_take;

  generate
    if (EDGE_MODE) begin : g_edge
      logic [N_IRQ-1:0] r_irq_prev;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_irq_prev <= '0;
        end else begin
          r_irq_prev <= bus.irq;
        end
      end

      assign w_set = bus.irq & ~r_irq_prev;
    end else begin : g_level
      assign w_set = bus.irq;
    end
  endgenerate

  assign w_cand = r_pending & r_enable;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (w_cand),
    .found (w_found),
    .idx   (w_sel)
  );

  // Arithmetic is done at ADDR_W so overflow wraps exactly like truncation.
  assign w_vec = VEC_BASE + ADDR_W'(w_sel) * ADDR_W'(VEC_STRIDE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Returning to IDLE never dispatches on the same edge, guaranteeing one
  // low cycle of s_interruption between back-to-back handlers.
  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = SERVICE;
          w_dispatch   = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.s_finished) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_dispatch) begin
      w_clr[w_sel] = 1'b1;
    end
  end

  // A fresh request on the dispatch edge survives the clear (OR after mask).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_enable  <= '1;
      r_dir     <= '0;
      r_id      <= '0;
      r_take    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (bus.en_we) begin
        r_enable <= bus.en_wdata;
      end
      if (w_dispatch) begin
        r_dir <= w_vec;
        r_id  <= w_sel;
      end
      r_take <= w_dispatch;
    end
  end

  assign bus.s_interruption = (r_state == SERVICE);
  assign bus.dir_out        = r_dir;
  assign bus.irq_id         = r_id;
  assign bus.irq_take       = r_take;
  assign bus.pending        = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module : tb_interrupt_controller
// Brief  : Edge-mode and level-mode controllers driven in lockstep against a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int IW = 2;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic [N-1:0] irq        = '0;
  logic         en_we      = 1'b0;
  logic [N-1:0] en_wdata   = '0;
  logic         s_finished = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_e;
  int cnt_l;

  always #5 clk = ~clk;

  interrupt_controller_if #(.N_IRQ(N), .ADDR_W(AW)) bus_e ();
  interrupt_controller_if #(.N_IRQ(N), .ADDR_W(AW)) bus_l ();

  assign bus_e.irq        = irq;
  assign bus_e.en_we      = en_we;
  assign bus_e.en_wdata   = en_wdata;
  assign bus_e.s_finished = s_finished;
  assign bus_l.irq        = irq;
  assign bus_l.en_we      = en_we;
  assign bus_l.en_wdata   = en_wdata;
  assign bus_l.s_finished = s_finished;

  interrupt_controller #(
    .N_IRQ(N), .ADDR_W(AW), .VEC_BASE(10'h200), .VEC_STRIDE(16), .EDGE_MODE(1'b1)
  ) dut_e (
    .clk(clk), .reset(reset), .bus(bus_e.slave)
  );

  interrupt_controller #(
    .N_IRQ(N), .ADDR_W(AW), .VEC_BASE(10'h200), .VEC_STRIDE(16), .EDGE_MODE(1'b0)
  ) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l.slave)
  );

  // Reference model, index 0 = edge mode, index 1 = level mode.
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_en   [2];
  logic [N-1:0] m_prev [2];
  logic         m_busy [2];
  logic         m_take [2];
  int           m_id   [2];
  int           m_dir  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0;
      m_en[m]   = '1;
      m_prev[m] = '0;
      m_busy[m] = 1'b0;
      m_take[m] = 1'b0;
      m_id[m]   = 0;
      m_dir[m]  = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] st;
      logic [N-1:0] cl;
      logic         got;
      st  = '0;
      cl  = '0;
      got = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (irq[i] && (m == 1 || !m_prev[m][i])) st[i] = 1'b1;
      end
      m_take[m] = 1'b0;
      if (m_busy[m]) begin
        if (s_finished) m_busy[m] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!got && m_pend[m][i] && m_en[m][i]) begin
            got       = 1'b1;
            m_busy[m] = 1'b1;
            m_take[m] = 1'b1;
            m_id[m]   = i;
            m_dir[m]  = (512 + i * 16) % 1024;
            cl[i]     = 1'b1;
          end
        end
      end
      m_pend[m] = (m_pend[m] & ~cl) | st;
      if (en_we) m_en[m] = en_wdata;
      m_prev[m] = irq;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int m, input string pfx, input logic si, input logic tk,
                           input logic [AW-1:0] dir, input logic [IW-1:0] id,
                           input logic [N-1:0] pd);
    chk({pfx, "_s_interruption"}, 32'(si),  32'(m_busy[m]));
    chk({pfx, "_irq_take"},       32'(tk),  32'(m_take[m]));
    chk({pfx, "_dir_out"},        32'(dir), 32'(m_dir[m]));
    chk({pfx, "_irq_id"},         32'(id),  32'(m_id[m]));
    chk({pfx, "_pending"},        32'(pd),  32'(m_pend[m]));
  endtask

  task automatic check_all();
    check_dut(0, "edge",  bus_e.s_interruption, bus_e.irq_take, bus_e.dir_out,
              bus_e.irq_id, bus_e.pending);
    check_dut(1, "level", bus_l.s_interruption, bus_l.irq_take, bus_l.dir_out,
              bus_l.irq_id, bus_l.pending);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();

    // Single timer pulse, then return.
    irq = 4'b0001; tick();
    irq = 4'b0000; tick();
    chk("t1_take", 32'(bus_e.irq_take), 32'h1);
    chk("t1_dir",  32'(bus_e.dir_out),  32'h200);
    repeat (3) tick();
    s_finished = 1'b1; tick();
    s_finished = 1'b0;
    chk("t1_idle", 32'(bus_e.s_interruption), 32'h0);
    chk("t1_pend", 32'(bus_e.pending), 32'h0);

    // Simultaneous sources 1 and 3.
    irq = 4'b1010; tick();
    irq = 4'b0000; tick();
    chk("t2_id1",  32'(bus_e.irq_id),  32'h1);
    chk("t2_dir1", 32'(bus_e.dir_out), 32'h210);
    repeat (2) tick();
    s_finished = 1'b1; tick();
    s_finished = 1'b0;
    chk("t2_gap", 32'(bus_e.s_interruption), 32'h0);
    tick();
    chk("t2_take3", 32'(bus_e.irq_take), 32'h1);
    chk("t2_dir3",  32'(bus_e.dir_out),  32'h230);
    s_finished = 1'b1; tick();
    s_finished = 1'b0; tick();

    // Masked source stays pending until re-enabled.
    en_we = 1'b1; en_wdata = 4'b1011; tick();
    en_we = 1'b0; irq = 4'b0100; tick();
    irq = 4'b0000; tick(); tick();
    chk("t3_pend", 32'(bus_e.pending), 32'h4);
    chk("t3_nodisp", 32'(bus_e.s_interruption), 32'h0);
    en_we = 1'b1; en_wdata = 4'b1111; tick();
    en_we = 1'b0; tick();
    chk("t3_id2",  32'(bus_e.irq_id),  32'h2);
    chk("t3_dir2", 32'(bus_e.dir_out), 32'h220);
    s_finished = 1'b1; tick();
    s_finished = 1'b0; tick();

    // No preemption while source 1 is in service.
    irq = 4'b0010; tick();
    irq = 4'b0000; tick();
    irq = 4'b0001; tick();
    irq = 4'b0000; tick(); tick();
    chk("t4_hold_dir", 32'(bus_e.dir_out), 32'h210);
    chk("t4_hold_id",  32'(bus_e.irq_id),  32'h1);
    s_finished = 1'b1; tick();
    s_finished = 1'b0; tick();
    chk("t4_id0", 32'(bus_e.irq_id), 32'h0);
    s_finished = 1'b1; tick();
    s_finished = 1'b0; tick();

    // Held request: one dispatch in edge mode, repeated in level mode.
    cnt_e = 0;
    cnt_l = 0;
    irq = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      s_finished = (c % 5 == 4);
      tick();
      if (bus_e.irq_take) cnt_e++;
      if (bus_l.irq_take) cnt_l++;
    end
    irq = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      s_finished = (c % 2 == 0);
      tick();
    end
    s_finished = 1'b0;
    chk("t5_edge_once", 32'(cnt_e), 32'd1);
    chk("t5_level_redispatch", 32'(cnt_l > 1), 32'd1);

    // Reset in the middle of service with source 2 pending.
    irq = 4'b0010; tick();
    irq = 4'b0000; tick();
    irq = 4'b0100; tick();
    irq = 4'b0000; tick();
    chk("t6_pend", 32'(bus_e.pending), 32'h4);
    async_reset_pulse();
    chk("t6_rst_dir", 32'(bus_e.dir_out), 32'h0);
    chk("t6_rst_si",  32'(bus_e.s_interruption), 32'h0);
    repeat (5) tick();
    chk("t6_quiet", 32'(bus_e.s_interruption), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      irq        = N'($urandom & $urandom & $urandom);
      en_we      = ($urandom_range(0, 19) == 0);
      en_wdata   = N'($urandom);
      s_finished = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
